// File: rtl/mc_pred_buf.sv
// Chroma prediction buffer for one 32x32 block: 8x8-granular half-block writes,
// registered 4/8/16/32 reads gated by a per-half-block completion map.
module mc_pred_buf #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      wr_ena_i,
    input  logic [1:0]                wr_siz_i,
    input  logic [3:0]                wr_4x4_x_i,
    input  logic [3:0]                wr_4x4_y_i,
    input  logic [4:0]                wr_idx_i,
    input  logic [32*PIXEL_WIDTH-1:0] wr_dat_i,
    input  logic                      rd_ena_i,
    input  logic [1:0]                rd_siz_i,
    input  logic [3:0]                rd_4x4_x_i,
    input  logic [3:0]                rd_4x4_y_i,
    input  logic [4:0]                rd_idx_i,
    output logic [32*PIXEL_WIDTH-1:0] rd_dat_o,
    output logic                      rd_vld_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    logic [PIXEL_WIDTH-1:0] pix_mem [32][32];
    logic [31:0]            half_map;
    logic                   done_latch;

    logic        wr_legal, wr_fire, wr_h, latch_cleared, done_set, rd_all_set;
    logic [1:0]  wr_by, wr_bx;
    logic [31:0] map_next;
    logic [32*PIXEL_WIDTH-1:0] rd_word;

    wire unused_inputs = ^{wr_4x4_x_i[3], wr_4x4_x_i[0], wr_4x4_y_i[3], wr_4x4_y_i[0],
                           rd_4x4_x_i[3], rd_4x4_y_i[3]};

    assign wr_by    = wr_4x4_y_i[2:1];
    assign wr_bx    = wr_4x4_x_i[2:1];
    assign wr_h     = wr_idx_i[2];
    assign wr_legal = (wr_siz_i == SIZE_08) && ((wr_idx_i == 5'd0) || (wr_idx_i == 5'd4));
    assign wr_fire  = wr_ena_i && wr_legal;

    // start_i clears before a same-cycle write marks its half
    always_comb begin
        map_next      = start_i ? '0 : half_map;
        latch_cleared = start_i ? 1'b0 : done_latch;
        if (wr_fire) begin
            map_next[{wr_by, wr_bx, wr_h}] = 1'b1;
        end
        done_set = wr_fire && (&map_next) && !latch_cleared;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 8; j++) begin
                    pix_mem[{wr_by, wr_h, k[1:0]}][{wr_bx, j[2:0]}] <=
                        wr_dat_i[(32 - (k*8 + j))*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
                end
            end
        end
    end

    // map index is {by, bx, h}; validity only covers halves the region touches
    always_comb begin
        rd_word    = '0;
        rd_all_set = 1'b0;
        case (rd_siz_i)
            SIZE_32: begin
                for (int p = 0; p < 32; p++) begin
                    rd_word[(32-p)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = pix_mem[rd_idx_i][p[4:0]];
                end
                rd_all_set = half_map[{rd_idx_i[4:3], 2'd0, rd_idx_i[2]}] &
                             half_map[{rd_idx_i[4:3], 2'd1, rd_idx_i[2]}] &
                             half_map[{rd_idx_i[4:3], 2'd2, rd_idx_i[2]}] &
                             half_map[{rd_idx_i[4:3], 2'd3, rd_idx_i[2]}];
            end
            SIZE_16: begin
                for (int p = 0; p < 32; p++) begin
                    rd_word[(32-p)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] =
                        pix_mem[{rd_4x4_y_i[2], rd_idx_i[2:0], p[4]}][{rd_4x4_x_i[2], p[3:0]}];
                end
                rd_all_set = half_map[{rd_4x4_y_i[2], rd_idx_i[2], rd_4x4_x_i[2], 1'b0, rd_idx_i[1]}] &
                             half_map[{rd_4x4_y_i[2], rd_idx_i[2], rd_4x4_x_i[2], 1'b1, rd_idx_i[1]}];
            end
            SIZE_08: begin
                for (int p = 0; p < 32; p++) begin
                    rd_word[(32-p)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] =
                        pix_mem[{rd_4x4_y_i[2:1], rd_idx_i[2], p[4:3]}][{rd_4x4_x_i[2:1], p[2:0]}];
                end
                rd_all_set = half_map[{rd_4x4_y_i[2:1], rd_4x4_x_i[2:1], rd_idx_i[2]}];
            end
            default: begin
                for (int p = 0; p < 16; p++) begin
                    rd_word[(32-p)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] =
                        pix_mem[{rd_4x4_y_i[2:0], p[3:2]}][{rd_4x4_x_i[2:0], p[1:0]}];
                end
                rd_all_set = half_map[{rd_4x4_y_i[2:1], rd_4x4_x_i[2:1], rd_4x4_y_i[0]}];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_map   <= '0;
            done_latch <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_dat_o   <= '0;
            rd_vld_o   <= 1'b0;
        end else begin
            half_map   <= map_next;
            done_latch <= latch_cleared | done_set;
            done_o     <= done_set;
            err_o      <= wr_ena_i && !wr_legal;
            if (rd_ena_i) begin
                rd_dat_o <= rd_word;
                rd_vld_o <= rd_all_set;
            end else begin
                rd_vld_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_pred_buf.sv
// Self-checking bench for mc_pred_buf against a pixel-coordinate reference model.
module tb_mc_pred_buf;

    localparam int PW = 8;
    localparam int DW = 32*PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0, wr_ena_i = 1'b0, rd_ena_i = 1'b0;
    logic [1:0]    wr_siz_i = '0, rd_siz_i = '0;
    logic [3:0]    wr_4x4_x_i = '0, wr_4x4_y_i = '0, rd_4x4_x_i = '0, rd_4x4_y_i = '0;
    logic [4:0]    wr_idx_i = '0, rd_idx_i = '0;
    logic [DW-1:0] wr_dat_i = '0;
    logic [DW-1:0] rd_dat_o;
    logic          rd_vld_o, done_o, err_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]    mmem [32][32];
    bit            mmap [4][4][2];
    bit            mlatch;
    logic [DW-1:0] exp_dat;
    logic          exp_vld, exp_done, exp_err;

    always #5 clk = ~clk;

    mc_pred_buf #(.PIXEL_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .wr_ena_i(wr_ena_i), .wr_siz_i(wr_siz_i), .wr_4x4_x_i(wr_4x4_x_i),
        .wr_4x4_y_i(wr_4x4_y_i), .wr_idx_i(wr_idx_i), .wr_dat_i(wr_dat_i),
        .rd_ena_i(rd_ena_i), .rd_siz_i(rd_siz_i), .rd_4x4_x_i(rd_4x4_x_i),
        .rd_4x4_y_i(rd_4x4_y_i), .rd_idx_i(rd_idx_i), .rd_dat_o(rd_dat_o),
        .rd_vld_o(rd_vld_o), .done_o(done_o), .err_o(err_o)
    );

    // Picture coordinates of output pixel p (MSB-first) for a read request
    task automatic coord(input logic [1:0] siz, input logic [3:0] x, input logic [3:0] y,
                         input logic [4:0] idx, input int p, output int r, output int c,
                         output bit used);
        used = 1'b1;
        case (siz)
            2'd3: begin r = int'(idx); c = p; end
            2'd2: begin r = int'(y[2])*16 + int'(idx[2:0])*2 + p/16; c = int'(x[2])*16 + p%16; end
            2'd1: begin r = int'(y[2:1])*8 + int'(idx[2])*4 + p/8; c = int'(x[2:1])*8 + p%8; end
            default: begin
                used = (p < 16);
                r = int'(y[2:0])*4 + (p%16)/4;
                c = int'(x[2:0])*4 + p%4;
            end
        endcase
    endtask

    task automatic model_reset();
        foreach (mmap[a, b, h]) mmap[a][b][h] = 1'b0;
        mlatch = 1'b0; exp_dat = '0; exp_vld = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_step();
        int r, c; bit used, legal, full;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rd_ena_i) begin
            exp_vld = 1'b1;
            for (int p = 0; p < 32; p++) begin
                coord(rd_siz_i, rd_4x4_x_i, rd_4x4_y_i, rd_idx_i, p, r, c, used);
                if (used) begin
                    exp_dat[(32-p)*PW-1 -: PW] = mmem[r][c];
                    if (!mmap[r/8][c/8][(r%8)/4]) exp_vld = 1'b0;
                end else begin
                    exp_dat[(32-p)*PW-1 -: PW] = '0;
                end
            end
        end else begin
            exp_vld = 1'b0;
        end
        if (start_i) begin
            foreach (mmap[a, b, h]) mmap[a][b][h] = 1'b0;
            mlatch = 1'b0;
        end
        legal = (wr_siz_i == 2'd1) && (wr_idx_i == 5'd0 || wr_idx_i == 5'd4);
        if (wr_ena_i && !legal) exp_err = 1'b1;
        if (wr_ena_i && legal) begin
            for (int p = 0; p < 32; p++) begin
                r = int'(wr_4x4_y_i[2:1])*8 + int'(wr_idx_i[2])*4 + p/8;
                c = int'(wr_4x4_x_i[2:1])*8 + p%8;
                mmem[r][c] = wr_dat_i[(32-p)*PW-1 -: PW];
            end
            mmap[wr_4x4_y_i[2:1]][wr_4x4_x_i[2:1]][wr_idx_i[2]] = 1'b1;
            full = 1'b1;
            foreach (mmap[a, b, h]) if (!mmap[a][b][h]) full = 1'b0;
            if (full && !mlatch) begin exp_done = 1'b1; mlatch = 1'b1; end
        end
    endtask

    task automatic idle();
        start_i = 1'b0; wr_ena_i = 1'b0; rd_ena_i = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_write(input logic [1:0] siz, input int by, input int bx, input int h,
                             input logic [4:0] idx_override, input bit use_override,
                             input logic [DW-1:0] dat);
        wr_ena_i   = 1'b1;
        wr_siz_i   = siz;
        wr_4x4_x_i = 4'(bx*2);
        wr_4x4_y_i = 4'(by*2);
        wr_idx_i   = use_override ? idx_override : 5'(h*4);
        wr_dat_i   = dat;
    endtask

    task automatic set_read(input logic [1:0] siz, input logic [3:0] x, input logic [3:0] y,
                            input logic [4:0] idx);
        rd_ena_i = 1'b1; rd_siz_i = siz; rd_4x4_x_i = x; rd_4x4_y_i = y; rd_idx_i = idx;
    endtask

    function automatic logic [DW-1:0] rand_dat();
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] linear_dat(input int by, input int bx, input int h);
        logic [DW-1:0] d;
        for (int p = 0; p < 32; p++) d[(32-p)*PW-1 -: PW] = 8'((by*8 + h*4 + p/8)*32 + bx*8 + p%8);
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; idle(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_dat_o !== '0) begin errors++; $display("[TB] FAIL reset_dat: got %h want 0", rd_dat_o); end
        checks++; if (rd_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b want 0", rd_vld_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err_o); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_full_block();
        int pulses = 0;
        for (int n = 0; n < 32; n++) begin
            set_write(2'd1, n/8, (n/2)%4, n%2, '0, 1'b0, linear_dat(n/8, (n/2)%4, n%2));
            cycle();
            pulses += int'(done_o);
            checks++; if (done_o !== exp_done) begin errors++; $display("[TB] FAIL full_done[%0d]: got %b want %b", n, done_o, exp_done); end
        end
        cycle();
        pulses += int'(done_o);
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL full_pulses: got %0d want 1", pulses); end
        for (int row = 0; row < 32; row++) begin
            set_read(2'd3, 4'($urandom), 4'($urandom), 5'(row));
            cycle();
            checks++;
            if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld || rd_vld_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL full_row%0d: got %h/%b want %h/%b", row, rd_dat_o, rd_vld_o, exp_dat, exp_vld);
            end
        end
    endtask

    task automatic test_random_reads();
        for (int i = 0; i < 24; i++) begin
            set_read(2'($urandom), 4'($urandom), 4'($urandom), 5'($urandom));
            cycle();
            checks++;
            if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
                errors++;
                $display("[TB] FAIL rand_read%0d: got %h/%b want %h/%b", i, rd_dat_o, rd_vld_o, exp_dat, exp_vld);
            end
        end
        cycle();
        checks++; if (rd_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_vld: got %b want 0", rd_vld_o); end
    endtask

    task automatic test_partial();
        start_i = 1'b1; cycle();
        set_write(2'd1, 2, 1, 0, '0, 1'b0, rand_dat()); cycle();
        set_write(2'd1, 2, 1, 1, '0, 1'b0, rand_dat()); cycle();
        set_read(2'd1, 4'd2, 4'd4, 5'd4); cycle();
        checks++;
        if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
            errors++; $display("[TB] FAIL partial_s8: got %h/%b want %h/%b", rd_dat_o, rd_vld_o, exp_dat, exp_vld);
        end
        set_read(2'd2, 4'd0, 4'd4, 5'd0); cycle();
        checks++;
        if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
            errors++; $display("[TB] FAIL partial_s16: got %h/%b want %h/%b", rd_dat_o, rd_vld_o, exp_dat, exp_vld);
        end
    endtask

    task automatic test_illegal();
        set_write(2'd2, 0, 0, 0, '0, 1'b0, rand_dat()); cycle();
        checks++; if (err_o !== exp_err) begin errors++; $display("[TB] FAIL err_siz: got %b want %b", err_o, exp_err); end
        cycle();
        checks++; if (err_o !== exp_err) begin errors++; $display("[TB] FAIL err_clear: got %b want %b", err_o, exp_err); end
        set_write(2'd1, 0, 0, 0, 5'd2, 1'b1, rand_dat()); cycle();
        checks++; if (err_o !== exp_err) begin errors++; $display("[TB] FAIL err_idx: got %b want %b", err_o, exp_err); end
        set_read(2'd1, 4'd0, 4'd0, 5'd0); cycle();
        checks++;
        if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld || err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL err_unchanged: got %h/%b want %h/%b", rd_dat_o, rd_vld_o, exp_dat, exp_vld);
        end
    endtask

    task automatic fill_missing(input string tag);
        int pulses = 0;
        for (int n = 0; n < 32; n++) begin
            if (!mmap[n/8][(n/2)%4][n%2]) begin
                set_write(2'd1, n/8, (n/2)%4, n%2, '0, 1'b0, rand_dat());
                cycle();
                pulses += int'(done_o);
                checks++; if (done_o !== exp_done) begin errors++; $display("[TB] FAIL %s_done[%0d]: got %b want %b", tag, n, done_o, exp_done); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL %s_pulses: got %0d want 1", tag, pulses); end
    endtask

    task automatic test_restart();
        fill_missing("prefill");
        start_i = 1'b1;
        set_write(2'd1, 0, 0, 0, '0, 1'b0, rand_dat());
        cycle();
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL restart_nodone: got %b want 0", done_o); end
        set_read(2'd1, 4'd0, 4'd0, 5'd0); cycle();
        checks++; if (rd_vld_o !== exp_vld || rd_dat_o !== exp_dat) begin errors++; $display("[TB] FAIL restart_h0: got %b want %b", rd_vld_o, exp_vld); end
        set_read(2'd1, 4'd0, 4'd0, 5'd4); cycle();
        checks++; if (rd_vld_o !== exp_vld) begin errors++; $display("[TB] FAIL restart_h1: got %b want %b", rd_vld_o, exp_vld); end
        fill_missing("refill");
    endtask

    task automatic test_same_cycle();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin start_i = 1'b1; cycle(); end
            set_write(2'd1, 3, 3, 1, '0, 1'b0, rand_dat());
            set_read(2'd1, 4'd6, 4'd6, 5'd4);
            cycle();
            checks++;
            if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
                errors++; $display("[TB] FAIL same_old%0d: got %h/%b want %h/%b", pass, rd_dat_o, rd_vld_o, exp_dat, exp_vld);
            end
            set_read(2'd1, 4'd6, 4'd6, 5'd4);
            cycle();
            checks++;
            if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
                errors++; $display("[TB] FAIL same_new%0d: got %h/%b want %h/%b", pass, rd_dat_o, rd_vld_o, exp_dat, exp_vld);
            end
        end
    endtask

    task automatic test_reset_midway();
        start_i = 1'b1; cycle();
        for (int n = 0; n < 10; n++) begin
            set_write(2'd1, n/8, (n/2)%4, n%2, '0, 1'b0, rand_dat());
            cycle();
        end
        set_read(2'd1, 4'd0, 4'd0, 5'd0); cycle();
        checks++; if (rd_vld_o !== exp_vld) begin errors++; $display("[TB] FAIL mid_pre_vld: got %b want %b", rd_vld_o, exp_vld); end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (rd_vld_o !== 1'b0 || rd_dat_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_async: got vld=%b dat=%h done=%b err=%b want all 0", rd_vld_o, rd_dat_o, done_o, err_o);
        end
        @(negedge clk) rst = 1'b0;
        set_read(2'd0, 4'd1, 4'd0, 5'($urandom)); cycle();
        checks++; if (rd_vld_o !== exp_vld) begin errors++; $display("[TB] FAIL mid_s4_empty: got %b want %b", rd_vld_o, exp_vld); end
        set_write(2'd1, 0, 0, 0, '0, 1'b0, rand_dat()); cycle();
        set_read(2'd0, 4'd1, 4'd0, 5'($urandom)); cycle();
        checks++;
        if (rd_dat_o !== exp_dat || rd_vld_o !== exp_vld) begin
            errors++; $display("[TB] FAIL mid_s4_full: got %h/%b want %h/%b", rd_dat_o, rd_vld_o, exp_dat, exp_vld);
        end
        fill_missing("postrst");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_full_block();
        test_random_reads();
        test_partial();
        test_illegal();
        test_restart();
        test_same_cycle();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
